spi_bus_arb: RTL and testbench

//  Shares one 16-bit SPI master between the inertial interface and the A2D interface, so the

---
 rtl/segway_spi_pkg.sv | 7 +
 rtl/arb_timer.sv | 17 +
 rtl/spi_bus_arb.sv | 99 +++++++++
 tb/tb_spi_bus_arb.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/segway_spi_pkg.sv
// segway_spi_pkg: SPI arbiter state type, SS_n select codes (ss_sel decode) and default timeout
package segway_spi_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} arb_state_t;
  localparam logic SEL_INERT = 1'b0;
  localparam logic SEL_A2D = 1'b1;
  localparam int DEF_TIMEOUT = 4096;
endpackage

// File: rtl/arb_timer.sv
// arb_timer: shared up-counter (clk, rst, clr, inc) flagging hit when the count equals term
module arb_timer #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         hit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (inc) cnt <= cnt + W'(1);
  assign hit = cnt == term;
endmodule

// File: rtl/spi_bus_arb.sv
// spi_bus_arb: shares one SPI master between inertial/A2D requesters (req/cmd in, gnt/done/rd_data out; wrt/cmd/spi_done/spi_rd_data to master; ss_sel, tmo_err)
module spi_bus_arb
  import segway_spi_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int GAP_CYC = 4,
  parameter int MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_inert,
  input  logic [15:0] cmd_inert,
  input  logic        req_a2d,
  input  logic [15:0] cmd_a2d,
  output logic        gnt_inert,
  output logic        gnt_a2d,
  output logic        done_inert,
  output logic        done_a2d,
  output logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        ss_sel,
  output logic        tmo_err
);
  localparam int TW = $clog2(TIMEOUT > GAP_CYC ? TIMEOUT : GAP_CYC);
  localparam int CW = $clog2(MAX_CONSEC + 1);
  arb_state_t state, state_n;
  logic [CW-1:0] consec, consec_n;
  logic gnt_inert_n, gnt_a2d_n, done_inert_n, done_a2d_n, wrt_n, ss_sel_n, tmo_err_n;
  logic [15:0] rd_data_n, cmd_n;
  logic grant, pick_a2d, fin, tmr_hit;
  // Timer is cleared on the grant edge so it reads 0 in LAUNCH; the abort then
  // lands exactly TIMEOUT cycles after wrt. The same counter times the GAP.
  arb_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (grant | fin),
    .inc  (state != IDLE),
    .term (state == GAP ? TW'(GAP_CYC - 1) : TW'(TIMEOUT - 1)),
    .hit  (tmr_hit)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      consec <= '0;
      gnt_inert <= 1'b0;
      gnt_a2d <= 1'b0;
      done_inert <= 1'b0;
      done_a2d <= 1'b0;
      rd_data <= 16'h0000;
      wrt <= 1'b0;
      cmd <= 16'h0000;
      ss_sel <= SEL_INERT;
      tmo_err <= 1'b0;
    end else begin
      state <= state_n;
      consec <= consec_n;
      gnt_inert <= gnt_inert_n;
      gnt_a2d <= gnt_a2d_n;
      done_inert <= done_inert_n;
      done_a2d <= done_a2d_n;
      rd_data <= rd_data_n;
      wrt <= wrt_n;
      cmd <= cmd_n;
      ss_sel <= ss_sel_n;
      tmo_err <= tmo_err_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (req_inert | req_a2d) ? LAUNCH : IDLE;
      LAUNCH:  state_n = BUSY;
      BUSY:    state_n = (spi_done | tmr_hit) ? GAP : BUSY;
      GAP:     state_n = tmr_hit ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  // A2D only beats a simultaneous inertial request once inertial has had
  // MAX_CONSEC back-to-back grants while A2D was waiting.
  always_comb begin
    grant = state == IDLE && (req_inert | req_a2d);
    pick_a2d = req_a2d && (!req_inert || consec == CW'(MAX_CONSEC));
    fin = state == BUSY && (spi_done | tmr_hit);
    consec_n = !grant ? consec :
               (pick_a2d || !req_a2d) ? '0 :
               (consec == CW'(MAX_CONSEC)) ? consec : consec + CW'(1);
    gnt_inert_n = grant ? !pick_a2d : fin ? 1'b0 : gnt_inert;
    gnt_a2d_n = grant ? pick_a2d : fin ? 1'b0 : gnt_a2d;
    ss_sel_n = grant ? (pick_a2d ? SEL_A2D : SEL_INERT) : ss_sel;
    cmd_n = grant ? (pick_a2d ? cmd_a2d : cmd_inert) : cmd;
    wrt_n = grant;
    done_inert_n = fin & gnt_inert;
    done_a2d_n = fin & gnt_a2d;
    tmo_err_n = state == BUSY && !spi_done && tmr_hit;
    rd_data_n = fin ? (spi_done ? spi_rd_data : 16'h0000) : rd_data;
  end
endmodule

// File: tb/tb_spi_bus_arb.sv
// tb_spi_bus_arb: directed stimulus with a cycle-timeline model checked every cycle plus literal spot checks
module tb_spi_bus_arb;
  import segway_spi_pkg::*;
  localparam int TMO = 16;
  localparam int GAP = 4;
  localparam int MAXC = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_inert = 1'b0, req_a2d = 1'b0, spi_done = 1'b0;
  logic [15:0] cmd_inert = 16'h0, cmd_a2d = 16'h0, spi_rd_data = 16'h0;
  logic gnt_inert, gnt_a2d, done_inert, done_a2d, wrt, ss_sel, tmo_err;
  logic [15:0] rd_data, cmd;
  int n_chk = 0, n_pass = 0, cyc = 0;
  bit armed = 0;
  logic e_gi = 0, e_ga = 0, e_di = 0, e_da = 0, e_wrt = 0, e_sel = 0, e_tmo = 0;
  logic [15:0] e_rd = 0, e_cmd = 0;
  bit m_busy = 0, m_own = 0;
  int launch = 0, free_at = 0, consec = 0;
  spi_bus_arb #(.TIMEOUT(TMO), .GAP_CYC(GAP), .MAX_CONSEC(MAXC)) dut (
    .clk(clk), .rst(rst),
    .req_inert(req_inert), .cmd_inert(cmd_inert),
    .req_a2d(req_a2d), .cmd_a2d(cmd_a2d),
    .gnt_inert(gnt_inert), .gnt_a2d(gnt_a2d),
    .done_inert(done_inert), .done_a2d(done_a2d),
    .rd_data(rd_data), .wrt(wrt), .cmd(cmd),
    .spi_done(spi_done), .spi_rd_data(spi_rd_data),
    .ss_sel(ss_sel), .tmo_err(tmo_err)
  );
  always #5 clk = ~clk;
  task automatic end_xact(input logic [15:0] d, input logic t);
    e_di = !m_own;
    e_da = m_own;
    e_tmo = t;
    e_rd = d;
    e_gi = 1'b0;
    e_ga = 1'b0;
    m_busy = 0;
    free_at = cyc + GAP;
  endtask
  // Timeline model: cyc is the cycle that begins at this edge. A grant in an
  // idle cycle puts wrt in the next one; spi_done seen after the wrt cycle, or
  // TIMEOUT cycles past wrt, ends the transfer; the bus is free GAP cycles
  // after the done pulse.
  always @(posedge clk) begin
    cyc++;
    armed = 1;
    e_wrt = 1'b0;
    e_di = 1'b0;
    e_da = 1'b0;
    e_tmo = 1'b0;
    if (rst) begin
      e_gi = 1'b0; e_ga = 1'b0; e_sel = 1'b0; e_rd = 16'h0; e_cmd = 16'h0;
      m_busy = 0; free_at = cyc; consec = 0;
    end else if (!m_busy && cyc - 1 >= free_at && (req_inert || req_a2d)) begin
      m_own = req_a2d && (!req_inert || consec == MAXC);
      consec = (m_own || !req_a2d) ? 0 : (consec < MAXC ? consec + 1 : consec);
      e_wrt = 1'b1;
      e_sel = m_own;
      e_cmd = m_own ? cmd_a2d : cmd_inert;
      e_gi = !m_own;
      e_ga = m_own;
      m_busy = 1;
      launch = cyc;
    end else if (m_busy && cyc - 1 > launch) begin
      if (spi_done) end_xact(spi_rd_data, 1'b0);
      else if (cyc - launch == TMO) end_xact(16'h0000, 1'b1);
    end
  end
  always @(negedge clk)
    if (armed) begin
      n_chk++;
      if ({gnt_inert, gnt_a2d, done_inert, done_a2d, wrt, ss_sel, tmo_err, rd_data, cmd} ===
          {e_gi, e_ga, e_di, e_da, e_wrt, e_sel, e_tmo, e_rd, e_cmd})
        n_pass++;
      else
        $display("FAIL cycle %0d outputs: got gi%b ga%b di%b da%b wrt%b sel%b tmo%b rd=%h cmd=%h want gi%b ga%b di%b da%b wrt%b sel%b tmo%b rd=%h cmd=%h",
                 cyc, gnt_inert, gnt_a2d, done_inert, done_a2d, wrt, ss_sel, tmo_err, rd_data, cmd,
                 e_gi, e_ga, e_di, e_da, e_wrt, e_sel, e_tmo, e_rd, e_cmd);
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic xact(input logic [15:0] d, input int dly, input logic own, input bit t,
                      output int wc, output int dc);
    int n = 0;
    while (!wrt && n < 200) begin tick(1); n++; end
    chk("wrt_seen", wrt, 1);
    chk("owner", ss_sel, own);
    wc = cyc;
    if (t) begin
      n = 0;
      while (!(done_inert || done_a2d) && n < 4 * TMO) begin tick(1); n++; end
      chk("tmo_err", tmo_err, 1);
      chk("tmo_latency", cyc - wc, TMO);
      chk("tmo_rd", rd_data, 0);
    end else begin
      tick(dly);
      spi_done = 1'b1;
      spi_rd_data = d;
      tick(1);
      spi_done = 1'b0;
      chk("rd_data", rd_data, d);
      chk("no_tmo", tmo_err, 0);
    end
    chk("done_owner", own ? done_a2d : done_inert, 1);
    dc = cyc;
    if (own) req_a2d = 1'b0;
    else req_inert = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int wc, dc, wc2, dc2, n;
    tick(3);
    chk("reset_outputs", |{gnt_inert, gnt_a2d, done_inert, done_a2d, wrt, ss_sel, tmo_err, rd_data, cmd}, 0);
    rst = 1'b0;
    tick(7);
    req_inert = 1'b1;
    cmd_inert = 16'hA5A5;
    tick(1);
    chk("wrt_cyc11", {cyc[7:0], 7'b0, wrt}, {8'd11, 8'h01});
    chk("cmd_a5a5", cmd, 16'hA5A5);
    chk("gnt_inert", {gnt_inert, gnt_a2d}, 2'b10);
    tick(2);
    spi_done = 1'b1;
    spi_rd_data = 16'h1234;
    tick(1);
    spi_done = 1'b0;
    req_inert = 1'b0;
    chk("done_inert_t1", done_inert, 1);
    chk("rd_1234", rd_data, 16'h1234);
    req_inert = 1'b1; cmd_inert = 16'h1111;
    req_a2d = 1'b1; cmd_a2d = 16'h0F0F;
    xact(16'hBEEF, 2, SEL_INERT, 0, wc, dc);
    xact(16'hCAFE, 2, SEL_A2D, 0, wc2, dc2);
    chk("a2d_after_gap", wc2, dc + GAP + 1);
    chk("cmd_a2d", cmd, 16'h0F0F);
    req_a2d = 1'b1; cmd_a2d = 16'h0A2D;
    for (int i = 0; i < 5; i++) begin
      req_inert = 1'b1;
      cmd_inert = 16'h1000 + 16'(i);
      xact(16'h5000 + 16'(i), 1, i == 4, 0, wc, dc);
    end
    tick(1);
    req_a2d = 1'b1;
    xact(16'h6000, 1, SEL_INERT, 0, wc, dc);
    xact(16'h6001, 1, SEL_A2D, 0, wc, dc);
    req_a2d = 1'b1; cmd_a2d = 16'h00AA;
    xact(16'h0000, 0, SEL_A2D, 1, wc, dc);
    req_inert = 1'b1; cmd_inert = 16'h4242;
    xact(16'h4242, 3, SEL_INERT, 0, wc, dc);
    req_a2d = 1'b1; cmd_a2d = 16'h5A5A;
    xact(16'h5A5A, TMO - 1, SEL_A2D, 0, wc, dc);
    req_inert = 1'b1; cmd_inert = 16'h7777;
    n = 0;
    while (!wrt && n < 200) begin tick(1); n++; end
    chk("wrt_before_rst", wrt, 1);
    tick(3);
    rst = 1'b1;
    req_inert = 1'b0;
    tick(1);
    rst = 1'b0;
    chk("rst_mid_outputs", |{gnt_inert, gnt_a2d, done_inert, done_a2d, wrt, ss_sel, tmo_err, rd_data, cmd}, 0);
    tick(2);
    spi_done = 1'b1;
    spi_rd_data = 16'hDEAD;
    tick(1);
    spi_done = 1'b0;
    chk("stray_done_ignored", {done_inert, done_a2d, rd_data}, 0);
    tick(20);
    chk("idle_no_wrt", {wrt, gnt_inert, gnt_a2d}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
